fsm_state_logger: RTL and testbench

- Downstream consumer of the 4-bit State output of the Y-driven FSM; samples State every clock.
- Records each state change as an entry {previous state, new state, dwell cycles} in a small first-word-fall-through FIFO.
- The FIFO is read through a valid/ready handshake by a monitor or debug port.
- Provides overflow and drop-count status so lost transitions are visible.

---
 rtl/fsm_state_logger.sv | 101 ++++++++++
 tb/tb_fsm_state_logger.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fsm_state_logger.sv
// Logs FSM state transitions {prev, new, dwell} into a FWFT FIFO read via valid/ready.
// Optional STATE_LOG_WMARK_EN adds a half_full watermark output.
module fsm_state_logger #(
  parameter int STATE_W = 4,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [STATE_W-1:0]             state_in,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [2*STATE_W+DWELL_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           overflow,
`ifdef STATE_LOG_WMARK_EN
  output logic                           half_full,
`endif
  output logic [7:0]                     drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [STATE_W-1:0] prev;
    logic [STATE_W-1:0] nxt;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]      remain, cnt_n;
  logic               armed;
  logic [STATE_W-1:0] prev_q;
  logic [DWELL_W-1:0] dwell;
  logic               change, full, pop, accept, drop;
  entry_t             push_ent, head_n;

  assign rd_valid = (count != '0);

  always_comb begin
    change   = armed && (state_in != prev_q);
    full     = (count == CW'(DEPTH));
    pop      = rd_valid && rd_ready;
    // a pop in the same cycle frees the slot the push needs
    accept   = change && (!full || pop);
    drop     = change && full && !pop;
    push_ent = '{prev: prev_q, nxt: state_in, dwell: dwell};
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    remain   = count - CW'(pop);
    cnt_n    = remain + CW'(accept);
    head_n   = entry_t'(rd_data);
    // registered head: if nothing older survives the pop, the new entry becomes head
    if (cnt_n != '0)
      head_n = (remain == '0) ? push_ent : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      prev_q   <= '0;
      dwell    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (!armed) begin
        armed  <= 1'b1;
        prev_q <= state_in;
        dwell  <= DWELL_W'(1);
      end else if (change) begin
        prev_q <= state_in;
        dwell  <= DWELL_W'(1);
      end else if (dwell != '1) begin
        dwell  <= dwell + 1'b1;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_n;
      count   <= cnt_n;
      rd_data <= head_n;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (rst_n && accept) mem[wr_ptr] <= push_ent;
  end

`ifdef STATE_LOG_WMARK_EN
  assign half_full = (count >= CW'(DEPTH/2));
`endif

endmodule

// File: tb/tb_fsm_state_logger.sv
// Directed bench for fsm_state_logger (DEPTH=8, STATE_W=4, DWELL_W=8).
module tb_fsm_state_logger;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  state_in = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
`ifdef STATE_LOG_WMARK_EN
  logic        half_full;
`endif
  int tests = 0;
  int fails = 0;

  fsm_state_logger #(.STATE_W(4), .DEPTH(8), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .state_in(state_in), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .overflow(overflow),
`ifdef STATE_LOG_WMARK_EN
    .half_full(half_full),
`endif
    .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  function automatic logic [15:0] ent(input logic [3:0] p, input logic [3:0] n, input logic [7:0] d);
    return {p, n, d};
  endfunction

  task automatic cyc(input logic [3:0] s, input logic r);
    state_in = s; rd_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(4'd0, 1'b0); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    tests++; if (rd_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h exp 0000", rd_data); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_ovf got %b/%0d exp 0/0", overflow, drop_cnt); end
`ifdef STATE_LOG_WMARK_EN
    tests++; if (half_full !== 1'b0) begin fails++; $display("FAIL reset_half got %b exp 0", half_full); end
`endif
  endtask

  task automatic test_first_entry();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(4'd0, 1'b0);
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL first_novalid got %b exp 0", rd_valid); end
    cyc(4'd3, 1'b0);
    tests++; if (rd_valid !== 1'b1 || count !== 4'd1) begin fails++; $display("FAIL first_cnt got %b/%0d exp 1/1", rd_valid, count); end
    tests++; if (rd_data !== ent(0, 3, 5)) begin fails++; $display("FAIL first_data got %h exp %h", rd_data, ent(0, 3, 5)); end
  endtask

  task automatic test_sequence_drain();
    logic [15:0] exp_q [3];
    exp_q[0] = ent(0, 1, 1); exp_q[1] = ent(1, 2, 1); exp_q[2] = ent(2, 3, 3);
    do_reset();
    cyc(4'd0, 1'b0); cyc(4'd1, 1'b0); cyc(4'd2, 1'b0);
    cyc(4'd2, 1'b0); cyc(4'd2, 1'b0); cyc(4'd3, 1'b0);
    tests++; if (count !== 4'd3) begin fails++; $display("FAIL seq_count got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin fails++; $display("FAIL seq_head%0d got %b/%h exp 1/%h", i, rd_valid, rd_data, exp_q[i]); end
      cyc(4'd3, 1'b1);
    end
    tests++; if (rd_valid !== 1'b0 || count !== 4'd0) begin fails++; $display("FAIL seq_empty got %b/%0d exp 0/0", rd_valid, count); end
    tests++; if (rd_data !== exp_q[2]) begin fails++; $display("FAIL seq_hold got %h exp %h", rd_data, exp_q[2]); end
  endtask

  task automatic test_overflow_and_full_pop();
    do_reset();
    cyc(4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) cyc((k % 2) ? 4'd1 : 4'd0, 1'b0);
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d exp 8", count); end
    tests++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin fails++; $display("FAIL ovf_flags got %b/%0d exp 1/2", overflow, drop_cnt); end
    tests++; if (rd_data !== ent(0, 1, 1)) begin fails++; $display("FAIL ovf_head got %h exp %h", rd_data, ent(0, 1, 1)); end
    // full + pop + change in the same cycle
    cyc(4'd5, 1'b1);
    tests++; if (count !== 4'd8 || drop_cnt !== 8'd2) begin fails++; $display("FAIL fullpop_cnt got %0d/%0d exp 8/2", count, drop_cnt); end
    tests++; if (rd_data !== ent(1, 0, 1)) begin fails++; $display("FAIL fullpop_head got %h exp %h", rd_data, ent(1, 0, 1)); end
    for (int i = 0; i < 7; i++) cyc(4'd5, 1'b1);
    tests++; if (count !== 4'd1 || rd_data !== ent(0, 5, 1)) begin fails++; $display("FAIL fullpop_tail got %0d/%h exp 1/%h", count, rd_data, ent(0, 5, 1)); end
    tests++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin fails++; $display("FAIL ovf_sticky got %b/%0d exp 1/2", overflow, drop_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(4'd0, 1'b1);
    tests++; if (count !== 4'd0 || rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_emptyrdy got %0d/%b exp 0/0", count, rd_valid); end
    cyc(4'd1, 1'b1);
    tests++; if (count !== 4'd1 || rd_data !== ent(0, 1, 1)) begin fails++; $display("FAIL b2b_push got %0d/%h exp 1/%h", count, rd_data, ent(0, 1, 1)); end
    cyc(4'd2, 1'b1);
    tests++; if (count !== 4'd1 || rd_data !== ent(1, 2, 1)) begin fails++; $display("FAIL b2b_pushpop got %0d/%h exp 1/%h", count, rd_data, ent(1, 2, 1)); end
    cyc(4'd2, 1'b1);
    tests++; if (count !== 4'd0 || rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %0d/%b exp 0/0", count, rd_valid); end
  endtask

  task automatic test_dwell_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) cyc(4'd7, 1'b0);
    cyc(4'd2, 1'b0);
    tests++; if (count !== 4'd1 || rd_data !== ent(7, 2, 255)) begin fails++; $display("FAIL sat_data got %0d/%h exp 1/%h", count, rd_data, ent(7, 2, 255)); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(4'd0, 1'b0);
    for (int k = 1; k <= 9; k++) cyc((k % 2) ? 4'd1 : 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(4'd1, 1'b1);
    tests++; if (count !== 4'd5 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin fails++; $display("FAIL mid_pre got %0d/%b/%0d exp 5/1/1", count, overflow, drop_cnt); end
    rst_n = 1'b0; cyc(4'd1, 1'b0); rst_n = 1'b1;
    tests++; if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin fails++; $display("FAIL mid_clear got %0d/%b/%b/%0d exp 0/0/0/0", count, rd_valid, overflow, drop_cnt); end
    cyc(4'd4, 1'b0); cyc(4'd6, 1'b0);
    tests++; if (count !== 4'd1 || rd_data !== ent(4, 6, 1)) begin fails++; $display("FAIL mid_rearm got %0d/%h exp 1/%h", count, rd_data, ent(4, 6, 1)); end
    cyc(4'd4, 1'b0); cyc(4'd6, 1'b0); cyc(4'd4, 1'b0);
    tests++; if (count !== 4'd4) begin fails++; $display("FAIL wm_cnt4 got %0d exp 4", count); end
`ifdef STATE_LOG_WMARK_EN
    tests++; if (half_full !== 1'b1) begin fails++; $display("FAIL wm_half4 got %b exp 1", half_full); end
`endif
    cyc(4'd4, 1'b1);
    tests++; if (count !== 4'd3 || rd_data !== ent(6, 4, 1)) begin fails++; $display("FAIL wm_cnt3 got %0d/%h exp 3/%h", count, rd_data, ent(6, 4, 1)); end
`ifdef STATE_LOG_WMARK_EN
    tests++; if (half_full !== 1'b0) begin fails++; $display("FAIL wm_half3 got %b exp 0", half_full); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_entry();
    test_sequence_drain();
    test_overflow_and_full_pop();
    test_back_to_back();
    test_dwell_saturate();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
